pdm_capture: RTL and testbench

Parametrised PDM microphone front end for one or more PDM data lines, each carrying a stereo pair of mics.
- Generates the shared `pdm_clk` from the system clock.
- Samples every line on both phases: left channel in the high phase, right channel in the low phase.
- Deserialises each channel into `WORD_W`-bit words.
- Queues complete multi-channel frames in a small FIFO behind a valid/ready stream.
- Sits between the board mic pins and the downstream decimation/filter logic.

---
 rtl/pdm_capture.sv | 169 ++++++++++++++++
 tb/tb_pdm_capture.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_capture.sv
// PDM microphone front end: shared pdm_clk divider, dual-edge stereo capture per line,
// per-channel deserialisation and a FWFT frame FIFO. Define PDM_ONES_COUNT_EN for boxcar ones-count words.
module pdm_capture #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned NUM_LINES  = 1,
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  output logic                            pdm_clk,
  input  logic [NUM_LINES-1:0]            mic_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [2*NUM_LINES*WORD_W-1:0]   m_data,
  output logic                            overflow
);

  localparam int unsigned NCH     = 2 * NUM_LINES;
  localparam int unsigned FRAME_W = NCH * WORD_W;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned BIT_W   = $clog2(WORD_W);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DIV_W-1:0]   div_cnt_q;
  logic               pdm_clk_q;
  logic               armed_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic               push_q;
  logic [WORD_W-1:0]  sh_q [NCH];
  logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic               valid_q, overflow_q;

  logic               phase_end, sample_l, sample_r, frame_done;
  logic               fifo_full, pop, do_push, drop;
  logic [FRAME_W-1:0] frame;

  // Sample strobes fire on the last clk cycle of each pdm_clk phase.
  always_comb begin
    phase_end  = en && (div_cnt_q == DIV_LAST);
    sample_l   = phase_end && pdm_clk_q;
    sample_r   = phase_end && !pdm_clk_q && armed_q;
    frame_done = sample_r && (bit_cnt_q == BIT_LAST);
  end

  // Divider, arming and bit counter; push request is independent of en so a completed frame survives a disable.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      push_q    <= 1'b0;
    end else begin
      push_q <= frame_done;
      if (!en) begin
        div_cnt_q <= '0;
        pdm_clk_q <= 1'b0;
        armed_q   <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        if (phase_end) begin
          div_cnt_q <= '0;
          pdm_clk_q <= !pdm_clk_q;
        end else begin
          div_cnt_q <= div_cnt_q + DIV_ONE;
        end
        if (sample_l) begin
          armed_q <= 1'b1;
        end
        if (sample_r) begin
          bit_cnt_q <= frame_done ? '0 : (bit_cnt_q + BIT_ONE);
        end
      end
    end
  end

  // Per-channel word builders: even channel takes L samples, odd channel takes R samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        sh_q[c] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
`ifdef PDM_ONES_COUNT_EN
        if (sample_l && (bit_cnt_q == '0)) begin
          sh_q[2*i]   <= {{(WORD_W-1){1'b0}}, mic_data[i]};
          sh_q[2*i+1] <= '0;
        end else if (sample_l) begin
          sh_q[2*i]   <= sh_q[2*i] + {{(WORD_W-1){1'b0}}, mic_data[i]};
        end
        if (sample_r) begin
          sh_q[2*i+1] <= sh_q[2*i+1] + {{(WORD_W-1){1'b0}}, mic_data[i]};
        end
`else
        if (sample_l) begin
          sh_q[2*i]   <= {sh_q[2*i][WORD_W-2:0], mic_data[i]};
        end
        if (sample_r) begin
          sh_q[2*i+1] <= {sh_q[2*i+1][WORD_W-2:0], mic_data[i]};
        end
`endif
      end
    end
  end

  // FIFO control; a push into a full FIFO succeeds only when the head leaves in the same cycle.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      frame[c*WORD_W +: WORD_W] = sh_q[c];
    end
    fifo_full = (count_q == CNT_FULL);
    pop       = valid_q && m_ready;
    do_push   = push_q && (!fifo_full || pop);
    drop      = push_q && fifo_full && !pop;
    count_d   = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy, registered valid and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      overflow_q <= overflow_q || drop;
    end
  end

  // Frame storage needs no reset; valid_q gates its visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= frame;
    end
  end

  assign pdm_clk  = pdm_clk_q;
  assign m_valid  = valid_q;
  assign m_data   = mem_q[rd_ptr_q];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pdm_capture.sv
// Directed self-checking bench for pdm_capture: divider timing, packing, backpressure,
// full push+pop, enable drop and the ones-count build variant.
module tb_pdm_capture;

  logic        clk = 1'b0;
  logic        rst, en, en_s, m_ready;
  logic [0:0]  mic_data;
  logic        pdm_clk, m_valid, overflow;
  logic [15:0] m_data;
  logic        pdm_clk_s, m_valid_s, overflow_s;
  logic [31:0] m_data_s;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pdm_capture #(.CLK_DIV(2), .NUM_LINES(1), .WORD_W(8), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .pdm_clk(pdm_clk), .mic_data(mic_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .overflow(overflow)
  );

  pdm_capture #(.CLK_DIV(25), .NUM_LINES(1), .WORD_W(16), .FIFO_DEPTH(4)) u_dut_slow (
    .clk(clk), .rst(rst), .en(en_s), .pdm_clk(pdm_clk_s), .mic_data(1'b0),
    .m_valid(m_valid_s), .m_ready(1'b1), .m_data(m_data_s), .overflow(overflow_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] wexp(input logic [7:0] b);
`ifdef PDM_ONES_COUNT_EN
    return 8'($countones(b));
`else
    return b;
`endif
  endfunction

  function automatic logic [15:0] fexp(input logic [7:0] l, input logic [7:0] r);
    return {wexp(r), wexp(l)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pdm(input logic lvl);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (pdm_clk === lvl) ok = 1'b1;
    end
    chk("pdm_wait", {31'd0, ok}, 32'd1);
  endtask

  // Drive n bits MSB first: L bit during the high phase, R bit during the low phase.
  task automatic send_bits(input logic [7:0] l, input logic [7:0] r, input int n);
    for (int k = 7; k > 7 - n; k--) begin
      wait_pdm(1'b1);
      mic_data = l[k];
      wait_pdm(1'b0);
      mic_data = r[k];
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en_s = 1'b0; m_ready = 1'b0; mic_data = 1'b0;
    repeat (3) tick();
    chk("rst_pdm", pdm_clk, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pdm_slow", pdm_clk_s, 0);

    // Divider at CLK_DIV=25: low for 25 cycles, then 50-cycle period.
    rst = 1'b0;
    en_s = 1'b1;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      chk($sformatf("slow_pdm_c%0d", k), pdm_clk_s, (k / 25) % 2);
    end
    chk("slow_valid", m_valid_s, 0);
    chk("slow_ovf", overflow_s, 0);
    tick();
    en_s = 1'b0;

    // Packing 0xA5 / 0x3C, valid two cycles after the final R sample.
    en = 1'b1; m_ready = 1'b1;
    send_bits(8'hA5, 8'h3C, 8);
    wait_pdm(1'b1);
    chk("pack_valid_t1", m_valid, 0);
    tick();
    chk("pack_valid_t2", m_valid, 1);
    chk("pack_data", m_data, fexp(8'hA5, 8'h3C));
    tick();
    chk("pack_popped", m_valid, 0);
    chk("pack_ovf", overflow, 0);

    // Backpressure: five frames into a depth-4 FIFO.
    en = 1'b0; m_ready = 1'b0;
    tick(); tick();
    en = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      send_bits(8'((1 << f) - 1), 8'h00, 8);
    end
    wait_pdm(1'b1);
    chk("bp_ovf_before", overflow, 0);
    tick();
    chk("bp_ovf_after", overflow, 1);
    en = 1'b0;
    tick();
    m_ready = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      chk($sformatf("bp_valid_%0d", f), m_valid, 1);
      chk($sformatf("bp_data_%0d", f), m_data, fexp(8'((1 << f) - 1), 8'h00));
      tick();
    end
    chk("bp_empty", m_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);
    m_ready = 1'b0;

    // Full FIFO with push and pop in the same cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("fp_ovf_rst", overflow, 0);
    en = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      send_bits(8'((1 << f) - 1), 8'h01, 8);
    end
    wait_pdm(1'b1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    chk("fp_ovf", overflow, 0);
    en = 1'b0;
    tick();
    m_ready = 1'b1;
    for (int f = 2; f <= 5; f++) begin
      chk($sformatf("fp_valid_%0d", f), m_valid, 1);
      chk($sformatf("fp_data_%0d", f), m_data, fexp(8'((1 << f) - 1), 8'h01));
      tick();
    end
    chk("fp_empty", m_valid, 0);
    m_ready = 1'b0;

    // Enable drop after three bits; the partial frame must never reach the FIFO.
    en = 1'b1;
    send_bits(8'h81, 8'h7E, 3);
    wait_pdm(1'b1);
    en = 1'b0;
    tick();
    chk("ed_pdm_low", pdm_clk, 0);
    tick();
    chk("ed_no_partial", m_valid, 0);
    en = 1'b1;
    send_bits(8'hFF, 8'h00, 8);
    wait_pdm(1'b1);
    chk("ed_valid_t1", m_valid, 0);
    tick();
    chk("ed_valid_t2", m_valid, 1);
    chk("ed_data", m_data, fexp(8'hFF, 8'h00));
    m_ready = 1'b1;
    tick();
    chk("ed_empty", m_valid, 0);
    m_ready = 1'b0;

    // L all ones, R = 0x55 (0x0408 in the ones-count build).
    en = 1'b0;
    tick();
    en = 1'b1;
    send_bits(8'hFF, 8'h55, 8);
    wait_pdm(1'b1);
    tick();
    chk("oc_valid", m_valid, 1);
    chk("oc_data", m_data, fexp(8'hFF, 8'h55));
    m_ready = 1'b1;
    tick();
    chk("oc_empty", m_valid, 0);
    chk("oc_ovf", overflow, 0);
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
